fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer and flag controller for the synchronous FIFO.
- Generates write enable, write address and read address for the FIFO's storage array, which has one write port and an asynchronous read port.
- Tracks occupancy and produces full/empty, almost-full/almost-empty and sticky overflow/underflow error flags.
- Reads are show-ahead: storage read data at r_addr is the head word whenever empty=0.

Parameters:
- ADDR_WIDTH, 2, address bits; FIFO depth DEPTH = 2**ADDR_WIDTH entries.
- AF_THRESH, 3, almost_full asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr  input  1  push request.
- rd  input  1  pop request.
- err_clr  input  1  clears the sticky error flags and the watermark.
- w_en  output  1  storage write enable. Combinational: wr & ~full.
- w_addr  output  ADDR_WIDTH  storage write address = wr_ptr[ADDR_WIDTH-1:0].
- r_addr  output  ADDR_WIDTH  storage read address = rd_ptr[ADDR_WIDTH-1:0].
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.
- max_count  output  ADDR_WIDTH+1  high-water mark (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, max_count = 0. Reset mid-operation discards all contents immediately.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide and wrap modulo 2**(ADDR_WIDTH+1). The MSB differs only when the FIFO is full, so full = (addr bits equal & MSB differ) and empty = (pointers equal).
- The count register is maintained in parallel with the pointers and must always equal wr_ptr - rd_ptr. A bench assertion checks this.
- Acceptance rules:
  - Push accepted iff wr & ~full.
  - Pop accepted iff rd & ~empty.
  - wr & rd while neither full nor empty: both accepted. count unchanged, both pointers advance.
  - wr & rd while full: pop only. count decrements; the write is dropped and sets overflow.
  - wr & rd while empty: push only. count increments; the pop is ignored and sets underflow. There is no fall-through: the new word is visible at r_addr the next cycle.
- Latency:
  - An accepted push updates wr_ptr/count/flags on the same edge that the storage captures data.
  - The pushed word is readable at r_addr in the next cycle.
  - An accepted pop advances rd_ptr on the edge; the next head appears the following cycle.
- Flags: all flags are derived from registered state only. No combinational path exists from wr/rd to the flags; the only combinational output path is wr → w_en.
- Errors:
  - overflow sets on any cycle with wr & full.
  - underflow sets on any cycle with rd & empty.
  - Both hold until err_clr. If err_clr and a new error occur in the same cycle, set wins.

Optional Feature:
- Macro: FIFO_CTRL_WATERMARK_EN.
- Defined: max_count registers the peak count since reset or the last err_clr. It updates to the new count on the edge where the new count exceeds max_count. err_clr loads max_count with the current post-edge count.
- Undefined: max_count is tied to 0 and no watermark logic is synthesized.
- In both cases the port list is unchanged.

Test Plan:
Defaults throughout: ADDR_WIDTH=2, DEPTH=4, AF_THRESH=3, AE_THRESH=1.
- Reset: assert rst_n=0 asynchronously mid-cycle with count=2 → all outputs at reset values immediately, empty=1, count=0, w_addr=r_addr=0.
- Fill then drain:
  - Push 4 words (0xA0..0xA3) with rd=0. count steps 1,2,3,4; almost_empty drops after the 2nd push, almost_full rises after the 3rd, full rises after the 4th; w_addr cycles 0,1,2,3.
  - Pop 4 words; storage data at r_addr reads 0xA0..0xA3 in order; empty=1 at end.
- Overflow/underflow:
  - At full, wr=1 for one cycle → w_en=0, count stays 4, overflow=1 and holds.
  - Drain, then rd=1 at empty → underflow=1, count stays 0.
  - Pulse err_clr → both flags 0.
- Simultaneous:
  - count=2 with wr=rd=1 for 3 cycles → count stays 2, both pointers advance 3 and wrap, data order preserved.
  - At full with wr=rd=1 → count 3, overflow=1.
  - At empty with wr=rd=1 → count 1, underflow=1.
- Wrap: 10 push/pop pairs with one word resident → w_addr/r_addr wrap 3→0 twice, no spurious full/empty.
- Watermark (macro defined): push 3, pop 3, push 1 → max_count=3; err_clr → max_count=1. With the macro undefined → max_count=0 throughout.

Source files
------------

// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and fifo_ctrl.
// master drives push/pop/clear requests; slave (fifo_ctrl) drives storage controls and flags.
interface fifo_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 2
);
    logic                  wr;
    logic                  rd;
    logic                  err_clr;
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   max_count;

    modport master (
        output wr, rd, err_clr,
        input  w_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow, max_count
    );

    modport slave (
        input  wr, rd, err_clr,
        output w_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
        output count, overflow, underflow, max_count
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO with show-ahead reads.
// Define FIFO_CTRL_WATERMARK_EN to build the max_count high-water mark; otherwise it reads 0.
module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned AF_THRESH  = 3,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo_ctrl_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] ONE    = 1;
    localparam logic [ADDR_WIDTH:0] AF_LVL = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_LVL = AE_THRESH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                full, empty, push, pop;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign push  = bus.wr & ~full;
    assign pop   = bus.rd & ~empty;

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + ONE : rd_ptr_q;
        count_d     = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as err_clr wins.
        overflow_d  = (overflow_q  & ~bus.err_clr) | (bus.wr & full);
        underflow_d = (underflow_q & ~bus.err_clr) | (bus.rd & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_CTRL_WATERMARK_EN
    logic [ADDR_WIDTH:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (bus.err_clr) begin
            max_d = count_d;
        end else if (count_d > max_q) begin
            max_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign bus.max_count = max_q;
`else
    assign bus.max_count = '0;
`endif

    assign bus.w_en         = push;
    assign bus.w_addr       = wr_ptr_q[ADDR_WIDTH-1:0];
    assign bus.r_addr       = rd_ptr_q[ADDR_WIDTH-1:0];
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_LVL);
    assign bus.almost_empty = (count_q <= AE_LVL);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (ADDR_WIDTH=2) with a small storage array driven by w_en/w_addr.
module tb_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wdata;
    logic [7:0] mem [4];
    logic [7:0] rdata;
    logic [1:0] addr_diff;
    int         checks = 0;
    int         errors = 0;

    fifo_ctrl_if #(.ADDR_WIDTH(2)) bus ();

    fifo_ctrl #(
        .ADDR_WIDTH(2),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.w_en) mem[bus.w_addr] <= wdata;
    end
    assign rdata     = mem[bus.r_addr];
    assign addr_diff = bus.w_addr - bus.r_addr;

    // Occupancy must always match the pointer distance.
    always @(negedge clk) begin
        checks++;
        assert (addr_diff === bus.count[1:0]) else begin
            errors++;
            $error("FAIL count_vs_ptrs: got %0d expected %0d", bus.count[1:0], addr_diff);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic w, input logic r, input logic c, input logic [7:0] d);
        bus.wr      = w;
        bus.rd      = r;
        bus.err_clr = c;
        wdata       = d;
    endtask

    initial begin
        logic [2:0] exp_wm;
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        #12;
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_ae", bus.almost_empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_af", bus.almost_full, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_unf", bus.underflow, 0);
        check("rst_max", bus.max_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two words in, then asynchronous reset mid-cycle.
        set_in(1'b1, 1'b0, 1'b0, 8'h11);
        tick();
        tick();
        check("pre_rst_count", bus.count, 2);
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", bus.count, 0);
        check("async_rst_empty", bus.empty, 1);
        check("async_rst_waddr", bus.w_addr, 0);
        check("async_rst_raddr", bus.r_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0xA0..0xA3.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
            #1;
            check("fill_wen", bus.w_en, 1);
            check("fill_waddr", bus.w_addr, i);
            tick();
            check("fill_count", bus.count, i + 1);
            check("fill_ae", bus.almost_empty, (i + 1) <= 1);
            check("fill_af", bus.almost_full, (i + 1) >= 3);
            check("fill_full", bus.full, i == 3);
        end

        // Push at full.
        set_in(1'b1, 1'b0, 1'b0, 8'hEE);
        #1;
        check("ovf_wen", bus.w_en, 0);
        tick();
        check("ovf_count", bus.count, 4);
        check("ovf_flag", bus.overflow, 1);
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("ovf_hold", bus.overflow, 1);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            check("drain_data", rdata, 8'hA0 + 8'(i));
            check("drain_empty", bus.empty, 0);
            set_in(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
        end
        check("drain_end_empty", bus.empty, 1);
        check("drain_end_count", bus.count, 0);

        // Pop at empty, then clear errors.
        tick();
        check("unf_count", bus.count, 0);
        check("unf_flag", bus.underflow, 1);
        set_in(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("clr_ovf", bus.overflow, 0);
        check("clr_unf", bus.underflow, 0);
        set_in(1'b0, 1'b0, 1'b0, 8'h00);

        // Two resident, then three simultaneous push/pop cycles.
        set_in(1'b1, 1'b0, 1'b0, 8'hB0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 8'hB1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("simul_head", rdata, 8'hB0 + 8'(i));
            set_in(1'b1, 1'b1, 1'b0, 8'hB2 + 8'(i));
            tick();
            check("simul_count", bus.count, 2);
        end
        check("simul_waddr", bus.w_addr, 1);
        check("simul_raddr", bus.r_addr, 3);
        check("simul_head_after", rdata, 8'hB3);

        // Fill to full, then push+pop at full.
        set_in(1'b1, 1'b0, 1'b0, 8'hC0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 8'hC1);
        tick();
        check("full2_full", bus.full, 1);
        set_in(1'b1, 1'b1, 1'b0, 8'hEE);
        #1;
        check("full_rw_wen", bus.w_en, 0);
        tick();
        check("full_rw_count", bus.count, 3);
        check("full_rw_ovf", bus.overflow, 1);
        check("full_rw_head", rdata, 8'hB4);

        // Drain, then push+pop at empty.
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check("drain2_head", rdata, 8'hC0);
        tick();
        check("drain2_head", rdata, 8'hC1);
        tick();
        check("drain2_empty", bus.empty, 1);
        set_in(1'b1, 1'b1, 1'b0, 8'hD0);
        tick();
        check("empty_rw_count", bus.count, 1);
        check("empty_rw_unf", bus.underflow, 1);
        check("empty_rw_head", rdata, 8'hD0);
        check("empty_rw_waddr", bus.w_addr, 0);
        check("empty_rw_raddr", bus.r_addr, 3);

        // Clear with the watermark loading the post-edge count of 1.
        set_in(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
`ifdef FIFO_CTRL_WATERMARK_EN
        exp_wm = 3'd1;
`else
        exp_wm = 3'd0;
`endif
        check("clr2_ovf", bus.overflow, 0);
        check("clr2_unf", bus.underflow, 0);
        check("clr2_max", bus.max_count, exp_wm);

        // Ten push/pop pairs with one word resident.
        for (int i = 0; i < 10; i++) begin
            check("wrap_head", rdata, (i == 0) ? 8'hD0 : 8'hE0 + 8'(i - 1));
            set_in(1'b1, 1'b1, 1'b0, 8'hE0 + 8'(i));
            tick();
            check("wrap_count", bus.count, 1);
            check("wrap_full", bus.full, 0);
            check("wrap_empty", bus.empty, 0);
        end
        check("wrap_waddr", bus.w_addr, 2);
        check("wrap_raddr", bus.r_addr, 1);
        check("wrap_head_last", rdata, 8'hE9);
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check("wrap_drain_empty", bus.empty, 1);

        // Watermark: clear at 0, push 3, pop 3, push 1, clear.
        set_in(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("wm_clr0", bus.max_count, 0);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 8'hF0 + 8'(i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
        end
        set_in(1'b1, 1'b0, 1'b0, 8'hF3);
        tick();
`ifdef FIFO_CTRL_WATERMARK_EN
        exp_wm = 3'd3;
`else
        exp_wm = 3'd0;
`endif
        check("wm_peak", bus.max_count, exp_wm);
        check("wm_count", bus.count, 1);
        set_in(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
`ifdef FIFO_CTRL_WATERMARK_EN
        exp_wm = 3'd1;
`else
        exp_wm = 3'd0;
`endif
        check("wm_after_clr", bus.max_count, exp_wm);
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
